// File: rtl/bus_regfile_pkg.sv
// Shared encodings for the bus register file: command opcodes and FSM states.
package bus_regfile_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_MOVE  = 2'b10,
    OP_SWAP  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_XFER  = 2'b10,
    ST_WRITE = 2'b11
  } state_e;

endpackage

// File: rtl/bus_reg_cell.sv
// Single WIDTH-bit storage register with synchronous reset and write enable.
module bus_reg_cell #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= '0;
    end else if (we_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/bus_register_file.sv
// NUM_REGS x WIDTH register file sharing one transfer bus, driven by a
// handshaked command FSM supporting LOAD, CLEAR, MOVE and SWAP.
module bus_register_file
  import bus_regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned NUM_REGS = 4,
  localparam int unsigned ADDR_W  = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_op_i,
  input  logic [ADDR_W-1:0]          cmd_src_i,
  input  logic [ADDR_W-1:0]          cmd_dst_i,
  input  logic [WIDTH-1:0]           data_bus_i,
  output logic [NUM_REGS*WIDTH-1:0]  reg_flat_o,
  output logic [WIDTH-1:0]           bus_out_o,
  output logic                       done_o,
  output logic                       error_o
);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NUM_REGS;
  endfunction

  state_e              state_q, state_d;
  op_e                 op_q;
  logic [ADDR_W-1:0]   src_q, dst_q;
  logic [WIDTH-1:0]    data_q;
  logic [WIDTH-1:0]    temp_q, temp_d;
  logic                bad_q;
  logic                done_q, error_q;

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] we;
  logic [WIDTH-1:0]    wdata;
  logic [WIDTH-1:0]    bus;
  logic [WIDTH-1:0]    src_val, dst_val;
  logic                accept;
  logic                acc_bad;
  op_e                 cmd_op;

  assign cmd_op      = op_e'(cmd_op_i);
  assign cmd_ready_o = (state_q == ST_IDLE) && !rst_i;
  assign accept      = cmd_valid_i && cmd_ready_o;
  // Only MOVE/SWAP use the source address, so only they can fault on it.
  assign acc_bad     = !in_range(cmd_dst_i) ||
                       (((cmd_op == OP_MOVE) || (cmd_op == OP_SWAP)) && !in_range(cmd_src_i));

  // Out-of-range addresses match no register and therefore read as zero.
  always_comb begin
    src_val = '0;
    dst_val = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) begin
      if (src_q == ADDR_W'(i)) src_val = regs[i];
      if (dst_q == ADDR_W'(i)) dst_val = regs[i];
    end
  end

  always_comb begin
    state_d = state_q;
    temp_d  = temp_q;
    we      = '0;
    wdata   = '0;
    bus     = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ((cmd_op == OP_LOAD) || (cmd_op == OP_CLEAR)) ? ST_WRITE : ST_FETCH;
        end
      end
      ST_FETCH: begin
        bus     = src_val;
        temp_d  = src_val;
        state_d = (op_q == OP_SWAP) ? ST_XFER : ST_WRITE;
      end
      ST_XFER: begin
        bus   = dst_val;
        wdata = dst_val;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
          we[i] = !bad_q && (src_q == ADDR_W'(i));
        end
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        unique case (op_q)
          OP_LOAD:  wdata = data_q;
          OP_CLEAR: wdata = '0;
          default:  wdata = temp_q;
        endcase
        bus = wdata;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
          we[i] = !bad_q && (dst_q == ADDR_W'(i));
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      src_q   <= '0;
      dst_q   <= '0;
      data_q  <= '0;
      temp_q  <= '0;
      bad_q   <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      temp_q  <= temp_d;
      done_q  <= (state_q == ST_WRITE);
      error_q <= (state_q == ST_WRITE) && bad_q;
      if (accept) begin
        op_q   <= cmd_op;
        src_q  <= cmd_src_i;
        dst_q  <= cmd_dst_i;
        data_q <= data_bus_i;
        bad_q  <= acc_bad;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_cell
    bus_reg_cell #(
      .WIDTH(WIDTH)
    ) u_cell (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .we_i (we[g]),
      .d_i  (wdata),
      .q_o  (regs[g])
    );
    assign reg_flat_o[g*WIDTH +: WIDTH] = regs[g];
  end

  assign bus_out_o = bus;
  assign done_o    = done_q;
  assign error_o   = error_q;

endmodule

// File: tb/tb_bus_register_file.sv
// Self-checking bench: a 4x16 and a 5x8 instance checked against a
// command-level model of register contents, handshake timing and bus values.
module tb_bus_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  op;
  logic [2:0]  src, dst;
  logic [15:0] data;
  logic        valid_a, valid_b;

  logic        ready_a, done_a, err_a;
  logic [63:0] flat_a;
  logic [15:0] bus_a;
  logic        ready_b, done_b, err_b;
  logic [39:0] flat_b;
  logic [7:0]  bus_b;

  int ncmp  = 0;
  int nfail = 0;

  logic [15:0] mdl [2][5];

  always #5 clk = ~clk;

  bus_register_file #(
    .WIDTH   (16),
    .NUM_REGS(4)
  ) u_dut_a (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(valid_a),
    .cmd_ready_o(ready_a),
    .cmd_op_i   (op),
    .cmd_src_i  (src[1:0]),
    .cmd_dst_i  (dst[1:0]),
    .data_bus_i (data),
    .reg_flat_o (flat_a),
    .bus_out_o  (bus_a),
    .done_o     (done_a),
    .error_o    (err_a)
  );

  bus_register_file #(
    .WIDTH   (8),
    .NUM_REGS(5)
  ) u_dut_b (
    .clk_i      (clk),
    .rst_i      (rst),
    .cmd_valid_i(valid_b),
    .cmd_ready_o(ready_b),
    .cmd_op_i   (op),
    .cmd_src_i  (src),
    .cmd_dst_i  (dst),
    .data_bus_i (data[7:0]),
    .reg_flat_o (flat_b),
    .bus_out_o  (bus_b),
    .done_o     (done_b),
    .error_o    (err_b)
  );

  function automatic int nregs(input bit b);
    return b ? 5 : 4;
  endfunction

  function automatic logic [15:0] mask(input bit b);
    return b ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic logic [15:0] rd(input bit b, input int a);
    return (a < nregs(b)) ? mdl[b][a] : 16'h0;
  endfunction

  function automatic logic [63:0] model_flat(input bit b);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < nregs(b); i++) begin
      if (b) f[i*8 +: 8] = mdl[b][i][7:0];
      else   f[i*16 +: 16] = mdl[b][i];
    end
    return f;
  endfunction

  function automatic logic [63:0] dut_flat(input bit b);
    return b ? {24'h0, flat_b} : flat_a;
  endfunction

  function automatic logic [15:0] dut_bus(input bit b);
    return b ? {8'h0, bus_b} : bus_a;
  endfunction

  function automatic logic dut_ready(input bit b);
    return b ? ready_b : ready_a;
  endfunction

  function automatic logic dut_done(input bit b);
    return b ? done_b : done_a;
  endfunction

  function automatic logic dut_err(input bit b);
    return b ? err_b : err_a;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 5; i++) mdl[b][i] = 16'h0;
  endtask

  // Called and returns at a falling edge. Next command may be issued straight away.
  task automatic run_cmd(input bit b, input int o, input int s, input int d,
                         input logic [15:0] dat);
    int          lat;
    bit          bad;
    logic [15:0] vs, vd, wv, ebus;
    op   = 2'(o);
    src  = 3'(s);
    dst  = 3'(d);
    data = dat;
    if (b) valid_b = 1'b1; else valid_a = 1'b1;
    check("ready_before_accept", 64'(dut_ready(b)), 64'd1);
    lat = (o == 2) ? 2 : (o == 3) ? 3 : 1;
    bad = (d >= nregs(b)) || (o >= 2 && s >= nregs(b));
    vs  = rd(b, s);
    vd  = rd(b, d);
    wv  = (o == 0) ? (dat & mask(b)) : (o == 1) ? 16'h0 : vs;
    @(posedge clk);
    for (int k = 0; k < lat; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Scramble inputs after acceptance; the latched command must be used.
        valid_a = 1'b0;
        valid_b = 1'b0;
        op   = 2'($urandom_range(3));
        src  = 3'($urandom_range(7));
        dst  = 3'($urandom_range(7));
        data = 16'($urandom);
      end
      check("busy_ready", 64'(dut_ready(b)), 64'd0);
      check("busy_done", 64'(dut_done(b)), 64'd0);
      if (k == lat - 1) ebus = wv;
      else if (k == 0)  ebus = vs;
      else              ebus = vd;
      if (!(bad && k == lat - 1)) check("bus_out", 64'(dut_bus(b)), 64'(ebus));
      if (o == 3 && k == 2 && !bad) begin
        mdl[b][s] = vd;
        check("swap_mid_flat", dut_flat(b), model_flat(b));
      end
      @(posedge clk);
    end
    @(negedge clk);
    if (!bad) mdl[b][d] = wv;
    check("done_pulse", 64'(dut_done(b)), 64'd1);
    check("error_flag", 64'(dut_err(b)), 64'(bad));
    check("ready_at_done", 64'(dut_ready(b)), 64'd1);
    check("regs_after_cmd", dut_flat(b), model_flat(b));
  endtask

  initial begin
    rst     = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    op      = 2'd0;
    src     = 3'd0;
    dst     = 3'd0;
    data    = 16'h0;
    clear_model();

    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_ready_a", 64'(ready_a), 64'd0);
      check("rst_ready_b", 64'(ready_b), 64'd0);
      check("rst_done", 64'(done_a), 64'd0);
      check("rst_flat_a", flat_a, 64'h0);
      check("rst_flat_b", 64'(flat_b), 64'h0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("post_rst_ready", 64'(ready_a), 64'd1);
    check("post_rst_done", 64'(done_a), 64'd0);

    // Back-to-back LOADs, then MOVE, SWAP and SWAP onto itself.
    run_cmd(1'b0, 0, 0, 0, 16'h000A);
    run_cmd(1'b0, 0, 0, 3, 16'h00B5);
    check("load_reg0", 64'(flat_a[15:0]), 64'h000A);
    check("load_reg3", 64'(flat_a[63:48]), 64'h00B5);
    check("load_reg12", 64'(flat_a[47:16]), 64'h0);
    @(negedge clk);
    check("done_single_cycle", 64'(done_a), 64'd0);
    run_cmd(1'b0, 2, 3, 1, 16'hFFFF);
    check("move_reg1", 64'(flat_a[31:16]), 64'h00B5);
    run_cmd(1'b0, 3, 0, 3, 16'h0);
    check("swap_reg0", 64'(flat_a[15:0]), 64'h00B5);
    check("swap_reg3", 64'(flat_a[63:48]), 64'h000A);
    run_cmd(1'b0, 0, 0, 2, 16'h1234);
    run_cmd(1'b0, 3, 2, 2, 16'h0);
    check("swap_self_reg2", 64'(flat_a[47:32]), 64'h1234);

    // Reset while a SWAP sits in XFER.
    op = 2'd3; src = 3'd0; dst = 3'd3; valid_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear_model();
    check("midrst_flat", flat_a, 64'h0);
    check("midrst_done", 64'(done_a), 64'd0);
    check("midrst_ready", 64'(ready_a), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("after_midrst_done", 64'(done_a), 64'd0);
    check("after_midrst_ready", 64'(ready_a), 64'd1);
    check("after_midrst_flat", flat_a, 64'h0);
    run_cmd(1'b0, 0, 0, 1, 16'hC0DE);

    for (int n = 0; n < 40; n++) begin
      run_cmd(1'b0, int'($urandom_range(3)), int'($urandom_range(3)),
              int'($urandom_range(3)), 16'($urandom));
    end

    // Non power-of-two instance: out-of-range handling.
    run_cmd(1'b1, 0, 0, 0, 16'h0077);
    run_cmd(1'b1, 0, 0, 6, 16'h00AA);
    run_cmd(1'b1, 0, 0, 4, 16'h005A);
    check("b_load_reg4", 64'(flat_b[39:32]), 64'h5A);
    run_cmd(1'b1, 1, 0, 4, 16'h00FF);
    check("b_clear_reg4", 64'(flat_b[39:32]), 64'h0);
    run_cmd(1'b1, 2, 7, 0, 16'h0);
    check("b_bad_move_reg0", 64'(flat_b[7:0]), 64'h77);
    run_cmd(1'b1, 3, 1, 5, 16'h0);
    for (int n = 0; n < 30; n++) begin
      run_cmd(1'b1, int'($urandom_range(3)), int'($urandom_range(7)),
              int'($urandom_range(7)), 16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
